flex_clock_bank: RTL and testbench

Parametrised bank of NCH independent derived clocks, all generated from one source clock. Each channel is a registered clock divider with a per-channel gate and a per-channel invert. All channel settings are reprogrammed through one valid/ready config port. Updates are applied only on a channel's falling-edge boundary, so derived clocks never show runt pulses or glitches. Sits in the clock-generation library beside the single-channel gated/make-clock primitives and feeds multi-domain test fabrics.

---
 rtl/flex_clock_bank.sv | 153 +++++++++++++++
 tb/tb_flex_clock_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/flex_clock_bank.sv
// flex_clock_bank: NCH glitch-free divided clocks from CLK, each with gate and invert,
// reprogrammed via one valid/ready port. Define FLEX_CLOCK_BANK_SYNC_EN to enable SYNC phase alignment.

module flex_clock_bank_ch #(
    parameter int   DIVW      = 8,
    parameter int   INIT_DIV  = 1,
    parameter logic INIT_GATE = 1'b1,
    parameter logic INIT_VAL  = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            sync,
    input  logic            load,
    input  logic [DIVW-1:0] ldiv,
    input  logic            lgate,
    input  logic            linv,
    output logic            val,
    output logic            gate,
    output logic            inv,
    output logic            pend,
    output logic            rise_next
);
    logic [DIVW-1:0] cnt, div, pdiv;
    logic            pgate, pinv;
    logic            at_end, fall;

    assign at_end    = (cnt == div);
    assign fall      = at_end & val;
    assign rise_next = at_end & ~val;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            val   <= INIT_VAL;
            div   <= DIVW'(INIT_DIV);
            gate  <= INIT_GATE;
            inv   <= 1'b0;
            pend  <= 1'b0;
            pdiv  <= '0;
            pgate <= 1'b0;
            pinv  <= 1'b0;
        end else begin
            if (sync) begin
                cnt <= '0;
                val <= INIT_VAL;
            end else begin
                cnt <= at_end ? '0 : cnt + DIVW'(1);
                if (at_end) val <= ~val;
            end
            // Settings only move on the falling edge, so high phases are never cut short.
            if (pend && (sync || fall)) begin
                div  <= pdiv;
                gate <= pgate;
                inv  <= pinv;
                pend <= 1'b0;
            end
            // A load only arrives while pend=0, so it can never be consumed by this same edge.
            if (load) begin
                pdiv  <= ldiv;
                pgate <= lgate;
                pinv  <= linv;
                pend  <= 1'b1;
            end
        end
    end
endmodule

module flex_clock_bank #(
    parameter int   NCH       = 4,
    parameter int   DIVW      = 8,
    parameter int   INIT_DIV  = 1,
    parameter logic INIT_GATE = 1'b1,
    parameter logic INIT_VAL  = 1'b0,
    localparam int  CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CFG_VALID,
    output logic            CFG_READY,
    input  logic [CHW-1:0]  CFG_CH,
    input  logic [DIVW-1:0] CFG_DIV,
    input  logic            CFG_GATE,
    input  logic            CFG_INVERT,
    output logic            CFG_ERR,
    input  logic            SYNC,
    output logic [NCH-1:0]  CLK_VAL_OUT,
    output logic [NCH-1:0]  CLK_GATE_OUT,
    output logic [NCH-1:0]  CLK_OUT,
    output logic [NCH-1:0]  RISE_NEXT
);
    typedef struct packed {
        logic [DIVW-1:0] div;
        logic            gate;
        logic            inv;
    } cfg_t;

    cfg_t           req;
    logic           in_range, sel_pend, xfer, sync_q;
    logic [NCH-1:0] load, pend, inv;

    assign req = '{div: CFG_DIV, gate: CFG_GATE, inv: CFG_INVERT};

`ifdef FLEX_CLOCK_BANK_SYNC_EN
    assign sync_q = SYNC;
`else
    logic unused_sync;
    assign unused_sync = SYNC;
    assign sync_q      = 1'b0;
`endif

    assign in_range  = (32'(CFG_CH) < 32'(NCH));
    assign CFG_READY = ~RST & (~in_range | ~sel_pend);
    assign xfer      = CFG_VALID & CFG_READY;

    always_comb begin
        sel_pend = 1'b0;
        load     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (32'(CFG_CH) == 32'(i)) begin
                sel_pend = pend[i];
                load[i]  = xfer;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) CFG_ERR <= 1'b0;
        else     CFG_ERR <= xfer & ~in_range;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        flex_clock_bank_ch #(
            .DIVW     (DIVW),
            .INIT_DIV (INIT_DIV),
            .INIT_GATE(INIT_GATE),
            .INIT_VAL (INIT_VAL)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .sync     (sync_q),
            .load     (load[g]),
            .ldiv     (req.div),
            .lgate    (req.gate),
            .linv     (req.inv),
            .val      (CLK_VAL_OUT[g]),
            .gate     (CLK_GATE_OUT[g]),
            .inv      (inv[g]),
            .pend     (pend[g]),
            .rise_next(RISE_NEXT[g])
        );
        assign CLK_OUT[g] = (CLK_VAL_OUT[g] & CLK_GATE_OUT[g]) ^ inv[g];
    end
endmodule

// File: tb/tb_flex_clock_bank.sv
// Directed bench for flex_clock_bank: reset, divide change, gate stall, invert, range error,
// mid-run reset and (with FLEX_CLOCK_BANK_SYNC_EN) SYNC alignment.

module tb_flex_clock_bank;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SYNC = 1'b0;
    logic       cfg_valid = 1'b0, cfg_gate = 1'b1, cfg_inv = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_ready, cfg_err;
    logic [3:0] val, gate_o, clk_o, rise;

    logic       e_valid = 1'b0, e_gate = 1'b1, e_inv = 1'b0;
    logic [2:0] e_ch = '0;
    logic [7:0] e_div = '0;
    logic       e_ready, e_err;
    logic [4:0] e_val, e_gate_o, e_clk_o, e_rise;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    flex_clock_bank #(.NCH(4)) u_dut (
        .CLK(CLK), .RST(RST), .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready),
        .CFG_CH(cfg_ch), .CFG_DIV(cfg_div), .CFG_GATE(cfg_gate), .CFG_INVERT(cfg_inv),
        .CFG_ERR(cfg_err), .SYNC(SYNC), .CLK_VAL_OUT(val), .CLK_GATE_OUT(gate_o),
        .CLK_OUT(clk_o), .RISE_NEXT(rise)
    );

    flex_clock_bank #(.NCH(5)) u_err (
        .CLK(CLK), .RST(RST), .CFG_VALID(e_valid), .CFG_READY(e_ready),
        .CFG_CH(e_ch), .CFG_DIV(e_div), .CFG_GATE(e_gate), .CFG_INVERT(e_inv),
        .CFG_ERR(e_err), .SYNC(SYNC), .CLK_VAL_OUT(e_val), .CLK_GATE_OUT(e_gate_o),
        .CLK_OUT(e_clk_o), .RISE_NEXT(e_rise)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic ev, er;
        RST = 1'b1;
        tick();
        tick();
        n_cmp++; if (val !== 4'h0)    begin n_fail++; $display("FAIL rst_val: got %h want 0", val); end
        n_cmp++; if (clk_o !== 4'h0)  begin n_fail++; $display("FAIL rst_clk: got %h want 0", clk_o); end
        n_cmp++; if (gate_o !== 4'hF) begin n_fail++; $display("FAIL rst_gate: got %h want f", gate_o); end
        n_cmp++; if (rise !== 4'h0)   begin n_fail++; $display("FAIL rst_rise: got %h want 0", rise); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", cfg_ready); end
        n_cmp++; if (cfg_err !== 1'b0 || e_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b/%b want 0/0", cfg_err, e_err); end
        RST = 1'b0;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", cfg_ready); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            ev = ((k / 2) % 2) == 1;
            er = (k % 4) == 1;
            n_cmp++; if (val !== {4{ev}})   begin n_fail++; $display("FAIL base_val k=%0d: got %h want %h", k, val, {4{ev}}); end
            n_cmp++; if (clk_o !== {4{ev}}) begin n_fail++; $display("FAIL base_clk k=%0d: got %h want %h", k, clk_o, {4{ev}}); end
            n_cmp++; if (rise !== {4{er}})  begin n_fail++; $display("FAIL base_rise k=%0d: got %h want %h", k, rise, {4{er}}); end
        end
    endtask

    task automatic test_div_change;
        logic ev;
        do_reset();
        tick();
        tick();
        n_cmp++; if (val[2] !== 1'b1) begin n_fail++; $display("FAIL div_pre: got %b want 1", val[2]); end
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; cfg_gate = 1'b1; cfg_inv = 1'b0;
        for (int k = 3; k <= 15; k++) begin
            tick();
            if (k == 3) begin
                n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL div_stall: got %b want 0", cfg_ready); end
                cfg_valid = 1'b0;
            end
            if (k == 4) begin
                n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL div_free: got %b want 1", cfg_ready); end
            end
            ev = (k == 3) ? 1'b1 : (((k - 4) / 4) % 2) == 1;
            n_cmp++; if (val[2] !== ev) begin n_fail++; $display("FAIL div_val2 k=%0d: got %b want %b", k, val[2], ev); end
            ev = ((k / 2) % 2) == 1;
            n_cmp++; if (val[0] !== ev) begin n_fail++; $display("FAIL div_val0 k=%0d: got %b want %b", k, val[0], ev); end
            if (k == 7 || k == 15) begin
                n_cmp++; if (rise[2] !== 1'b1) begin n_fail++; $display("FAIL div_rise k=%0d: got %b want 1", k, rise[2]); end
            end
        end
    endtask

    task automatic test_gate_stall;
        logic ev, eo;
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1; cfg_gate = 1'b0; cfg_inv = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k <= 3) begin
                n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL gate_stall k=%0d: got %b want 0", k, cfg_ready); end
            end
            if (k == 4 || k == 8) begin
                n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL gate_free k=%0d: got %b want 1", k, cfg_ready); end
            end
            if (k == 5) begin
                n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL gate_second k=%0d: got %b want 0", k, cfg_ready); end
                cfg_valid = 1'b0;
            end
            ev = ((k / 2) % 2) == 1;
            eo = (k == 2 || k == 3);
            n_cmp++; if (clk_o[1] !== eo)       begin n_fail++; $display("FAIL gate_clk k=%0d: got %b want %b", k, clk_o[1], eo); end
            n_cmp++; if (gate_o[1] !== (k < 4)) begin n_fail++; $display("FAIL gate_eff k=%0d: got %b want %b", k, gate_o[1], k < 4); end
            n_cmp++; if (val[1] !== ev)         begin n_fail++; $display("FAIL gate_val k=%0d: got %b want %b", k, val[1], ev); end
        end
    endtask

    task automatic test_invert;
        logic ev, eo;
        do_reset();
        tick(); tick(); tick();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_gate = 1'b1; cfg_inv = 1'b1;
        for (int k = 4; k <= 11; k++) begin
            tick();
            if (k == 4) begin
                n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL inv_pend: got %b want 0", cfg_ready); end
                cfg_valid = 1'b0;
            end
            ev = ((k / 2) % 2) == 1;
            eo = (k >= 8) ? ~ev : ev;
            n_cmp++; if (clk_o[0] !== eo) begin n_fail++; $display("FAIL inv_clk k=%0d: got %b want %b", k, clk_o[0], eo); end
            n_cmp++; if (val[0] !== ev)   begin n_fail++; $display("FAIL inv_val k=%0d: got %b want %b", k, val[0], ev); end
        end
    endtask

    task automatic test_cfg_err;
        logic ev;
        do_reset();
        e_valid = 1'b1; e_ch = 3'd5; e_div = 8'd3; e_gate = 1'b0; e_inv = 1'b1;
        #1;
        n_cmp++; if (e_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready0: got %b want 1", e_ready); end
        n_cmp++; if (e_err !== 1'b0)   begin n_fail++; $display("FAIL err_idle: got %b want 0", e_err); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                n_cmp++; if (e_err !== 1'b1)   begin n_fail++; $display("FAIL err_pulse: got %b want 1", e_err); end
                n_cmp++; if (e_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready1: got %b want 1", e_ready); end
                e_valid = 1'b0;
            end else begin
                n_cmp++; if (e_err !== 1'b0) begin n_fail++; $display("FAIL err_once k=%0d: got %b want 0", k, e_err); end
            end
            ev = ((k / 2) % 2) == 1;
            n_cmp++; if (e_val !== {5{ev}})   begin n_fail++; $display("FAIL err_val k=%0d: got %h want %h", k, e_val, {5{ev}}); end
            n_cmp++; if (e_clk_o !== {5{ev}}) begin n_fail++; $display("FAIL err_clk k=%0d: got %h want %h", k, e_clk_o, {5{ev}}); end
            n_cmp++; if (e_gate_o !== 5'h1F)  begin n_fail++; $display("FAIL err_gate k=%0d: got %h want 1f", k, e_gate_o); end
        end
    endtask

    task automatic test_reset_midway;
        logic ev;
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd3; cfg_gate = 1'b0; cfg_inv = 1'b1;
        tick();
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pend: got %b want 0", cfg_ready); end
        cfg_valid = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        n_cmp++; if (val !== 4'h0 || clk_o !== 4'h0) begin n_fail++; $display("FAIL mid_rst_out: got %h/%h want 0/0", val, clk_o); end
        n_cmp++; if (gate_o !== 4'hF)    begin n_fail++; $display("FAIL mid_rst_gate: got %h want f", gate_o); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", cfg_ready); end
        RST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ev = ((k / 2) % 2) == 1;
            if (k == 1) begin
                n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_lost: got %b want 1", cfg_ready); end
            end
            n_cmp++; if (val[3] !== ev)      begin n_fail++; $display("FAIL mid_val k=%0d: got %b want %b", k, val[3], ev); end
            n_cmp++; if (clk_o[3] !== ev)    begin n_fail++; $display("FAIL mid_clk k=%0d: got %b want %b", k, clk_o[3], ev); end
            n_cmp++; if (gate_o[3] !== 1'b1) begin n_fail++; $display("FAIL mid_gate k=%0d: got %b want 1", k, gate_o[3]); end
        end
    endtask

`ifdef FLEX_CLOCK_BANK_SYNC_EN
    task automatic test_sync;
        logic ev, er;
        int   j;
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_gate = 1'b1; cfg_inv = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) cfg_valid = 1'b0;
            if (k == 4) begin cfg_valid = 1'b1; cfg_ch = 2'd3; end
            if (k == 5) cfg_valid = 1'b0;
            if (k == 11) begin
                n_cmp++; if (val[0] !== 1'b0 || val[3] !== 1'b1) begin n_fail++; $display("FAIL sync_skew: got %b/%b want 0/1", val[0], val[3]); end
            end
            if (k == 12) SYNC = 1'b1;
            if (k == 13) SYNC = 1'b0;
            if (k >= 13) begin
                j  = k - 13;
                ev = ((j / 3) % 2) == 1;
                er = (j % 6) == 2;
                n_cmp++; if (val[0] !== ev || val[3] !== ev)  begin n_fail++; $display("FAIL sync_val k=%0d: got %b/%b want %b", k, val[0], val[3], ev); end
                n_cmp++; if (rise[0] !== er || rise[3] !== er) begin n_fail++; $display("FAIL sync_rise k=%0d: got %b/%b want %b", k, rise[0], rise[3], er); end
                ev = ((j / 2) % 2) == 1;
                n_cmp++; if (val[1] !== ev) begin n_fail++; $display("FAIL sync_ch1 k=%0d: got %b want %b", k, val[1], ev); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div_change();
        test_gate_stall();
        test_invert();
        test_cfg_err();
        test_reset_midway();
`ifdef FLEX_CLOCK_BANK_SYNC_EN
        test_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
